// File: rtl/imem_fetch_q_if.sv
// Fetch-side bus for imem_fetch_q: programming port, flush, request and response handshakes.
// The fetch/PC logic uses the master modport; the instruction memory uses the slave modport.
interface imem_fetch_q_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 6
) ();
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [N-1:0]      prog_data;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;

  modport master (
    output prog_we, prog_addr, prog_data, flush,
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, flush,
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_fetch_q.sv
// LEGv8 instruction memory: registered read, runtime programming port, flush,
// and a 3-entry response queue so fetch can run at full rate while decode stalls.
module imem_fetch_q #(
  parameter int    N         = 32,
  parameter int    ADDR_W    = 6,
  parameter int    DEPTH     = 64,
  parameter string INIT_FILE = ""
) (
  input  logic         clk,
  input  logic         reset,
  imem_fetch_q_if.slave bus
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [N-1:0] r_mem [DEPTH];

  // Memory contents survive reset; they come only from the programming port.
  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
  end

  logic              r_s1_valid;
  logic [N-1:0]      r_s1_rdata;
  logic [ADDR_W-1:0] r_s1_addr;
  logic              r_s1_err;

  logic [N-1:0]      r_q_data [3];
  logic [ADDR_W-1:0] r_q_addr [3];
  logic              r_q_err  [3];
  logic [1:0]        r_wptr;
  logic [1:0]        r_rptr;
  logic [1:0]        r_count;

  logic              w_req_in;
  logic              w_prog_in;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_rsp_valid;
  logic [N-1:0]      w_push_data;
  logic [2:0]        w_occupancy;

  function automatic logic [1:0] f_next_ptr(input logic [1:0] ptr);
    return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

  assign w_req_in    = {1'b0, bus.req_addr}  < LP_DEPTH;
  assign w_prog_in   = {1'b0, bus.prog_addr} < LP_DEPTH;
  assign w_rd_idx    = w_req_in  ? bus.req_addr[IDX_W-1:0]  : '0;
  assign w_wr_idx    = bus.prog_addr[IDX_W-1:0];

  // Counting the in-flight stage-1 word reserves its queue slot, so a push never overflows.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_s1_valid};
  assign w_req_ready = !bus.flush && (w_occupancy < 3'd3);
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_rsp_valid = (r_count != 2'd0);
  assign w_push      = r_s1_valid && !bus.flush;
  assign w_pop       = w_rsp_valid && bus.rsp_ready && !bus.flush;
  assign w_push_data = r_s1_err ? '0 : r_s1_rdata;

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = w_rsp_valid ? r_q_data[r_rptr] : '0;
  assign bus.rsp_addr  = w_rsp_valid ? r_q_addr[r_rptr] : '0;
  assign bus.rsp_err   = w_rsp_valid ? r_q_err[r_rptr]  : 1'b0;

  always_ff @(posedge clk) begin
    if (bus.prog_we && w_prog_in) r_mem[w_wr_idx] <= bus.prog_data;
  end

  // Read-first: the array is sampled at the same edge a programming write lands.
  always_ff @(posedge clk) begin
    if (w_accept) r_s1_rdata <= r_mem[w_rd_idx];
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_data[r_wptr] <= w_push_data;
      r_q_addr[r_wptr] <= r_s1_addr;
      r_q_err[r_wptr]  <= r_s1_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_err   <= 1'b0;
      r_wptr     <= 2'd0;
      r_rptr     <= 2'd0;
      r_count    <= 2'd0;
    end else if (bus.flush) begin
      r_s1_valid <= 1'b0;
      r_wptr     <= 2'd0;
      r_rptr     <= 2'd0;
      r_count    <= 2'd0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_addr <= bus.req_addr;
        r_s1_err  <= !w_req_in;
      end
      if (w_push) r_wptr <= f_next_ptr(r_wptr);
      if (w_pop)  r_rptr <= f_next_ptr(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
